// File: rtl/pll_reset_sequencer.sv
// PLL reset controller and reset-release sequencer driven by the synchronised PLL lock.
// Releases the SDRAM-domain reset before the system reset; reruns the sequence on lock loss or lock timeout.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 1048576,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned SDR_TO_SYS_CYCLES  = 64,
  parameter int unsigned LOCK_LOSS_FILTER   = 4,
  parameter int unsigned SOFT_RESET_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sdr_reset,
  output logic       sys_reset,
  output logic       running,
  output logic [7:0] relock_count
);

  localparam int unsigned RST_W  = $clog2(PLL_RST_CYCLES) + 1;
  localparam int unsigned TO_W   = $clog2(LOCK_TIMEOUT) + 1;
  localparam int unsigned STB_W  = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int unsigned SDR_W  = $clog2(SDR_TO_SYS_CYCLES) + 1;
  localparam int unsigned LOSS_W = $clog2(LOCK_LOSS_FILTER) + 1;
  localparam int unsigned SOFT_W = $clog2(SOFT_RESET_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_SDR_REL   = 3'd3,
    S_RUN       = 3'd4,
    S_SOFT      = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync_q;
  logic                locked_s;
  logic [RST_W-1:0]    rst_cnt_q,  rst_cnt_d;
  logic [TO_W-1:0]     to_cnt_q,   to_cnt_d;
  logic [STB_W-1:0]    stb_cnt_q,  stb_cnt_d;
  logic [SDR_W-1:0]    sdr_cnt_q,  sdr_cnt_d;
  logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic [SOFT_W-1:0]   soft_cnt_q, soft_cnt_d;
  logic                relock_inc;
  logic [7:0]          relock_d;
  logic                pll_rst_d, sdr_reset_d, sys_reset_d, running_d;
  logic                loss_hit;

  assign locked_s = sync_q[1];
  assign loss_hit = !locked_s && (loss_cnt_q == LOSS_W'(LOCK_LOSS_FILTER - 1));

  // State, counters, lock synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_PLL_RST;
      sync_q       <= 2'b00;
      rst_cnt_q    <= '0;
      to_cnt_q     <= '0;
      stb_cnt_q    <= '0;
      sdr_cnt_q    <= '0;
      loss_cnt_q   <= '0;
      soft_cnt_q   <= '0;
      relock_count <= 8'd0;
      pll_rst      <= 1'b1;
      sdr_reset    <= 1'b1;
      sys_reset    <= 1'b1;
      running      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], pll_locked};
      rst_cnt_q    <= rst_cnt_d;
      to_cnt_q     <= to_cnt_d;
      stb_cnt_q    <= stb_cnt_d;
      sdr_cnt_q    <= sdr_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      soft_cnt_q   <= soft_cnt_d;
      relock_count <= relock_d;
      pll_rst      <= pll_rst_d;
      sdr_reset    <= sdr_reset_d;
      sys_reset    <= sys_reset_d;
      running      <= running_d;
    end
  end

  // Next state; counters default to zero so each state starts counting from zero on entry
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = '0;
    to_cnt_d   = '0;
    stb_cnt_d  = '0;
    sdr_cnt_d  = '0;
    loss_cnt_d = '0;
    soft_cnt_d = '0;
    relock_inc = 1'b0;

    unique case (state_q)
      S_PLL_RST: begin
        if (rst_cnt_q == RST_W'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
        else                                         rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
          state_d    = S_PLL_RST;
          relock_inc = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_STABLE: begin
        if (!locked_s)                                         state_d = S_WAIT_LOCK;
        else if (stb_cnt_q == STB_W'(LOCK_STABLE_CYCLES - 1))  state_d = S_SDR_REL;
        else                                                   stb_cnt_d = stb_cnt_q + STB_W'(1);
      end
      S_SDR_REL: begin
        if (!locked_s) begin
          state_d    = S_PLL_RST;
          relock_inc = 1'b1;
        end else if (sdr_cnt_q == SDR_W'(SDR_TO_SYS_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          sdr_cnt_d = sdr_cnt_q + SDR_W'(1);
        end
      end
      S_RUN: begin
        if (loss_hit) begin
          state_d    = S_PLL_RST;
          relock_inc = 1'b1;
        end else if (soft_reset_req) begin
          state_d = S_SOFT;
        end else if (!locked_s) begin
          loss_cnt_d = loss_cnt_q + LOSS_W'(1);
        end
      end
      S_SOFT: begin
        if (loss_hit) begin
          state_d    = S_PLL_RST;
          relock_inc = 1'b1;
        end else if (soft_cnt_q == SOFT_W'(SOFT_RESET_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          soft_cnt_d = soft_cnt_q + SOFT_W'(1);
          if (!locked_s) loss_cnt_d = loss_cnt_q + LOSS_W'(1);
        end
      end
      default: state_d = S_PLL_RST;
    endcase

    relock_d    = (relock_inc && relock_count != 8'hFF) ? relock_count + 8'd1 : relock_count;
    pll_rst_d   = (state_d == S_PLL_RST);
    sdr_reset_d = (state_d == S_PLL_RST) || (state_d == S_WAIT_LOCK) || (state_d == S_STABLE);
    sys_reset_d = (state_d != S_RUN);
    running_d   = (state_d == S_RUN);
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: expected outputs are queued per clock cycle and
// compared on the falling edge when that cycle arrives.
module tb_pll_reset_sequencer;

  localparam int unsigned P = 4;
  localparam int unsigned T = 50;
  localparam int unsigned S = 8;
  localparam int unsigned D = 3;
  localparam int unsigned F = 4;
  localparam int unsigned K = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst, sdr_reset, sys_reset, running;
  logic [7:0] relock_count;
  logic [11:0] obs;

  typedef struct {
    int          at;
    string       tag;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES    (P),
    .LOCK_TIMEOUT      (T),
    .LOCK_STABLE_CYCLES(S),
    .SDR_TO_SYS_CYCLES (D),
    .LOCK_LOSS_FILTER  (F),
    .SOFT_RESET_CYCLES (K)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .soft_reset_req(soft_reset_req),
    .pll_rst       (pll_rst),
    .sdr_reset     (sdr_reset),
    .sys_reset     (sys_reset),
    .running       (running),
    .relock_count  (relock_count)
  );

  assign obs = {pll_rst, sdr_reset, sys_reset, running, relock_count};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected output vector {pll_rst, sdr_reset, sys_reset, running, relock_count}
  function automatic logic [11:0] v(logic p, logic s, logic y, logic r, int unsigned n);
    return {p, s, y, r, 8'(n)};
  endfunction

  task automatic push(int at, string tag, logic [11:0] val);
    exp_t e;
    e.at  = at;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  // Release sequence once S_STABLE is entered after edge st
  task automatic expect_seq(int st, int unsigned n, string tag);
    push(st + S - 1,     {tag, "_pre_sdr"}, v(0, 1, 1, 0, n));
    push(st + S,         {tag, "_sdr_rel"}, v(0, 0, 1, 0, n));
    push(st + S + D - 1, {tag, "_pre_sys"}, v(0, 0, 1, 0, n));
    push(st + S + D,     {tag, "_run"},     v(0, 0, 0, 1, n));
  endtask

  task automatic wait_until(int t);
    if (cyc > t) begin
      $display("FAIL wait_until: cycle %0d already past target %0d", cyc, t);
      $fatal(1, "bench schedule overrun");
    end
    while (cyc != t) @(negedge clk);
  endtask

  // Scoreboard comparison on the falling edge
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        checks++;
        assert (obs === sb[i].val) else begin
          errors++;
          $error("FAIL %s @cycle %0d: observed %h expected %h", sb[i].tag, cyc, obs, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, r, l;
    reset          = 1'b1;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;

    // Power-up: reset values, 4-cycle PLL reset, lock 10 cycles after release
    push(2, "reset_state", v(1, 1, 1, 0, 0));
    wait_until(3);
    r = cyc;
    reset = 1'b0;
    push(r + 1, "pll_rst_hi1", v(1, 1, 1, 0, 0));
    push(r + P - 1, "pll_rst_hi4", v(1, 1, 1, 0, 0));
    push(r + P, "pll_rst_lo", v(0, 1, 1, 0, 0));
    wait_until(r + 10);
    pll_locked = 1'b1;
    l = r + 11;
    push(l + 1, "pwr_wait", v(0, 1, 1, 0, 0));
    expect_seq(l + 2, 0, "pwr");

    // Run glitch of 3 cycles is filtered
    wait_until(r + 30);
    c = cyc;
    pll_locked = 1'b0;
    push(c + 4, "glitch3_a", v(0, 0, 0, 1, 0));
    push(c + 6, "glitch3_b", v(0, 0, 0, 1, 0));
    push(c + 8, "glitch3_c", v(0, 0, 0, 1, 0));
    wait_until(c + 3);
    pll_locked = 1'b1;

    // 4-cycle loss with a coincident soft request: loss wins, full resequence
    wait_until(c + 12);
    c = cyc;
    pll_locked = 1'b0;
    push(c + 5, "loss4_pre", v(0, 0, 0, 1, 0));
    push(c + 6, "loss4_hit", v(1, 1, 1, 0, 1));
    push(c + 9, "loss4_pll", v(1, 1, 1, 0, 1));
    push(c + 10, "loss4_wait", v(0, 1, 1, 0, 1));
    expect_seq(c + 11, 1, "reseq");
    wait_until(c + 4);
    pll_locked = 1'b1;
    wait_until(c + 5);
    soft_reset_req = 1'b1;
    wait_until(c + 6);
    soft_reset_req = 1'b0;

    // Soft reset: 5-cycle sys_reset pulse, second request ignored
    wait_until(c + 25);
    c = cyc;
    soft_reset_req = 1'b1;
    push(c + 1, "soft_start", v(0, 0, 1, 0, 1));
    push(c + 3, "soft_mid", v(0, 0, 1, 0, 1));
    push(c + K, "soft_last", v(0, 0, 1, 0, 1));
    push(c + K + 1, "soft_done", v(0, 0, 0, 1, 1));
    push(c + K + 3, "soft_noext", v(0, 0, 0, 1, 1));
    wait_until(c + 1);
    soft_reset_req = 1'b0;
    wait_until(c + 2);
    soft_reset_req = 1'b1;
    wait_until(c + 3);
    soft_reset_req = 1'b0;

    // Glitch at stable count 5 restarts the stable window
    wait_until(c + 10);
    c = cyc;
    pll_locked = 1'b0;
    push(c + 6, "stb_loss", v(1, 1, 1, 0, 2));
    push(c + 24, "stb_glitch", v(0, 1, 1, 0, 2));
    push(c + 26, "stb_no_early", v(0, 1, 1, 0, 2));
    push(c + 28, "stb_no_early2", v(0, 1, 1, 0, 2));
    expect_seq(c + 25, 2, "stb");
    wait_until(c + 15);
    pll_locked = 1'b1;
    wait_until(c + 21);
    pll_locked = 1'b0;
    wait_until(c + 22);
    pll_locked = 1'b1;

    // Unfiltered loss in S_SDR_REL, then mid-operation reset in S_SDR_REL
    wait_until(c + 40);
    c = cyc;
    pll_locked = 1'b0;
    push(c + 6, "sdr_pre_loss", v(1, 1, 1, 0, 3));
    push(c + 26, "sdr_rel_a", v(0, 0, 1, 0, 3));
    push(c + 27, "sdr_rel_b", v(0, 0, 1, 0, 3));
    push(c + 28, "sdr_loss", v(1, 1, 1, 0, 4));
    push(c + 32, "sdr_wait", v(0, 1, 1, 0, 4));
    push(c + 41, "sdr_rel2", v(0, 0, 1, 0, 4));
    push(c + 42, "sdr_rel2_b", v(0, 0, 1, 0, 4));
    push(c + 43, "mid_reset", v(1, 1, 1, 0, 0));
    wait_until(c + 15);
    pll_locked = 1'b1;
    wait_until(c + 25);
    pll_locked = 1'b0;
    wait_until(c + 26);
    pll_locked = 1'b1;
    wait_until(c + 42);
    reset = 1'b1;
    wait_until(c + 44);
    reset = 1'b0;
    r = cyc;
    push(r + P - 1, "mr_pll_hi", v(1, 1, 1, 0, 0));
    push(r + P, "mr_pll_lo", v(0, 1, 1, 0, 0));
    expect_seq(r + P + 1, 0, "mr");

    // Lock timeout retries and relock_count saturation
    wait_until(r + 20);
    reset = 1'b1;
    pll_locked = 1'b0;
    wait_until(r + 22);
    reset = 1'b0;
    r = cyc;
    push(r + P, "to_wait", v(0, 1, 1, 0, 0));
    push(r + 21, "to_soft_ign", v(0, 1, 1, 0, 0));
    push(r + 22, "to_soft_ign2", v(0, 1, 1, 0, 0));
    for (int k = 1; k <= 3; k++) begin
      push(r + (P + T) * k - 1, $sformatf("to%0d_pre", k), v(0, 1, 1, 0, k - 1));
      push(r + (P + T) * k, $sformatf("to%0d_hit", k), v(1, 1, 1, 0, k));
      push(r + (P + T) * k + P - 1, $sformatf("to%0d_pll", k), v(1, 1, 1, 0, k));
      push(r + (P + T) * k + P, $sformatf("to%0d_wait", k), v(0, 1, 1, 0, k));
    end
    for (int k = 254; k <= 257; k++) begin
      push(r + (P + T) * k, $sformatf("sat%0d", k), v(1, 1, 1, 0, (k > 255) ? 255 : k));
    end
    wait_until(r + 20);
    soft_reset_req = 1'b1;
    wait_until(r + 21);
    soft_reset_req = 1'b0;

    wait_until(r + (P + T) * 257 + 2);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
